// File: rtl/pwm_capture_if.sv
// Custom-instruction handshake shared by the PWM capture unit and its CPU-side master.
interface pwm_capture_if;
  logic        start;
  logic [7:0]  ci_n;
  logic [31:0] value_a;
  logic [31:0] value_b;
  logic        done;
  logic [31:0] result;

  modport master (output start, ci_n, value_a, value_b, input done, result);
  modport slave  (input start, ci_n, value_a, value_b, output done, result);
endinterface

// File: rtl/pwm_capture.sv
// Two-channel PWM input capture: measures high time and rise-to-rise period in clock cycles,
// read back through the custom-instruction handshake.
module pwm_capture #(
  parameter logic [7:0]  CustomId = 8'h00,
  parameter int unsigned CntWidth = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   pwm_i,
  pwm_capture_if.slave ci
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [1:0]          s1_q, s2_q, s3_q;
  logic [1:0]          rise, fall;
  logic [1:0]          wv_q, pv_q, tmo_q;
  state_e              st_q       [2];
  logic [CntWidth-1:0] hi_cnt_q   [2];
  logic [CntWidth-1:0] per_cnt_q  [2];
  logic [CntWidth-1:0] width_q    [2];
  logic [CntWidth-1:0] period_q   [2];

  logic sel, clr_en;

  assign sel    = ci.start && (ci.ci_n == CustomId);
  assign clr_en = sel && ci.value_a[3];
  assign rise   = s2_q & ~s3_q;
  assign fall   = ~s2_q & s3_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      wv_q  <= '0;
      pv_q  <= '0;
      tmo_q <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        st_q[ch]      <= StIdle;
        hi_cnt_q[ch]  <= '0;
        per_cnt_q[ch] <= '0;
        width_q[ch]   <= '0;
        period_q[ch]  <= '0;
      end
    end else begin
      s1_q <= pwm_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
      for (int ch = 0; ch < 2; ch++) begin
        // Clear first so a capture in the same cycle overrides it.
        if (clr_en && ci.value_b[ch]) begin
          wv_q[ch]  <= 1'b0;
          pv_q[ch]  <= 1'b0;
          tmo_q[ch] <= 1'b0;
        end
        unique case (st_q[ch])
          StIdle: begin
            if (rise[ch]) begin
              hi_cnt_q[ch]  <= CntOne;
              per_cnt_q[ch] <= CntOne;
              st_q[ch]      <= StHigh;
            end
          end
          StHigh: begin
            if (fall[ch]) begin
              width_q[ch]   <= hi_cnt_q[ch];
              wv_q[ch]      <= 1'b1;
              per_cnt_q[ch] <= per_cnt_q[ch] + CntOne;
              st_q[ch]      <= StLow;
            end else if (per_cnt_q[ch] == CntMax) begin
              tmo_q[ch] <= 1'b1;
              wv_q[ch]  <= 1'b0;
              pv_q[ch]  <= 1'b0;
              st_q[ch]  <= StIdle;
            end else begin
              hi_cnt_q[ch]  <= hi_cnt_q[ch] + CntOne;
              per_cnt_q[ch] <= per_cnt_q[ch] + CntOne;
            end
          end
          StLow: begin
            if (rise[ch]) begin
              period_q[ch]  <= per_cnt_q[ch];
              pv_q[ch]      <= 1'b1;
              hi_cnt_q[ch]  <= CntOne;
              per_cnt_q[ch] <= CntOne;
              st_q[ch]      <= StHigh;
            end else if (per_cnt_q[ch] == CntMax) begin
              tmo_q[ch] <= 1'b1;
              wv_q[ch]  <= 1'b0;
              pv_q[ch]  <= 1'b0;
              st_q[ch]  <= StIdle;
            end else begin
              per_cnt_q[ch] <= per_cnt_q[ch] + CntOne;
            end
          end
          default: st_q[ch] <= StIdle;
        endcase
      end
    end
  end

  function automatic logic [31:0] fmt(input logic v, input logic t,
                                      input logic [CntWidth-1:0] val);
    return {v, t, 10'b0, 20'(val)};
  endfunction

  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    unique case (ci.value_a[2:0])
      3'd0:    rd_data = fmt(wv_q[0], tmo_q[0], width_q[0]);
      3'd1:    rd_data = fmt(pv_q[0], tmo_q[0], period_q[0]);
      3'd2:    rd_data = fmt(wv_q[1], tmo_q[1], width_q[1]);
      3'd3:    rd_data = fmt(pv_q[1], tmo_q[1], period_q[1]);
      3'd4:    rd_data = {24'b0, s2_q, tmo_q, pv_q, wv_q};
      default: rd_data = '0;
    endcase
  end

  assign ci.done   = sel;
  assign ci.result = sel ? rd_data : 32'h0;

  logic unused_vals;
  assign unused_vals = ^{ci.value_a[31:4], ci.value_b[31:2]};

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model checked every cycle, plus directed
// scenarios with literal expectations. Counter width is reduced so timeouts are reachable.
module tb_pwm_capture;

  localparam logic [7:0]  Id   = 8'h2C;
  localparam int unsigned CntW = 12;
  localparam longint      TmoCnt = (longint'(1) << CntW) - 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] pwm   = 2'b00;

  pwm_capture_if bus ();

  pwm_capture #(
    .CustomId (Id),
    .CntWidth (CntW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .pwm_i (pwm),
    .ci    (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: edges found on the twice-delayed pin, measurements as timestamp deltas.
  bit     m_s1 [2], m_s2 [2], m_s3 [2];
  bit     m_wv [2], m_pv [2], m_tmo [2];
  int     m_mode [2];  // 0 idle, 1 measuring high, 2 measuring low
  longint m_rise_t [2];
  longint m_width [2], m_period [2];
  longint t = 0;
  longint age;
  bit     m_rs, m_fl;

  task automatic m_timeout(input int ch);
    m_tmo[ch]  = 1'b1;
    m_wv[ch]   = 1'b0;
    m_pv[ch]   = 1'b0;
    m_mode[ch] = 0;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_s1[ch] = 0; m_s2[ch] = 0; m_s3[ch] = 0;
        m_wv[ch] = 0; m_pv[ch] = 0; m_tmo[ch] = 0;
        m_mode[ch] = 0; m_width[ch] = 0; m_period[ch] = 0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        m_rs = m_s2[ch] && !m_s3[ch];
        m_fl = !m_s2[ch] && m_s3[ch];
        if (bus.start && bus.ci_n == Id && bus.value_a[3] && bus.value_b[ch]) begin
          m_wv[ch] = 0; m_pv[ch] = 0; m_tmo[ch] = 0;
        end
        age = t - m_rise_t[ch];
        case (m_mode[ch])
          0: if (m_rs) begin m_rise_t[ch] = t; m_mode[ch] = 1; end
          1: if (m_fl) begin
               m_width[ch] = age; m_wv[ch] = 1; m_mode[ch] = 2;
             end else if (age == TmoCnt) m_timeout(ch);
          default: if (m_rs) begin
               m_period[ch] = age; m_pv[ch] = 1; m_rise_t[ch] = t; m_mode[ch] = 1;
             end else if (age == TmoCnt) m_timeout(ch);
        endcase
        m_s3[ch] = m_s2[ch];
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = pwm[ch];
      end
    end
    t++;
  end

  function automatic logic [31:0] fmt(input bit v, input bit tm, input longint val);
    logic [19:0] f;
    f = val[19:0];
    return {v, tm, 10'b0, f};
  endfunction

  function automatic logic [31:0] model_rd(input logic [2:0] s);
    case (s)
      3'd0: return fmt(m_wv[0], m_tmo[0], m_width[0]);
      3'd1: return fmt(m_pv[0], m_tmo[0], m_period[0]);
      3'd2: return fmt(m_wv[1], m_tmo[1], m_width[1]);
      3'd3: return fmt(m_pv[1], m_tmo[1], m_period[1]);
      3'd4: return {24'b0, m_s2[1], m_s2[0], m_tmo[1], m_tmo[0], m_pv[1], m_pv[0],
                    m_wv[1], m_wv[0]};
      default: return 32'h0;
    endcase
  endfunction

  logic        exp_sel;
  logic [31:0] exp_res;

  always @(negedge clock) begin
    if (chk_en) begin
      exp_sel = bus.start && (bus.ci_n == Id);
      exp_res = exp_sel ? model_rd(bus.value_a[2:0]) : 32'h0;
      check("model_done", {31'b0, bus.done}, {31'b0, exp_sel});
      check("model_result", bus.result, exp_res);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic [7:0] id, input logic [31:0] va, input logic [31:0] vb,
                    input logic [31:0] exp_r, input bit exp_d, input string name);
    bus.start = 1'b1; bus.ci_n = id; bus.value_a = va; bus.value_b = vb;
    @(negedge clock);
    check(name, bus.result, exp_r);
    check({name, "_done"}, {31'b0, bus.done}, {31'b0, exp_d});
    step();
    bus.start = 1'b0; bus.value_a = '0; bus.value_b = '0;
  endtask

  task automatic pulse(input int ch, input int hi, input int lo);
    pwm[ch] = 1'b1;
    repeat (hi) step();
    pwm[ch] = 1'b0;
    repeat (lo) step();
  endtask

  int         cnt [2];
  logic [31:0] va;

  initial begin
    bus.start = 1'b0; bus.ci_n = '0; bus.value_a = '0; bus.value_b = '0;
    repeat (3) step();
    reset = 1'b0;
    chk_en = 1'b1;

    for (int s = 0; s < 5; s++) op(Id, 32'(s), 32'h0, 32'h0, 1'b1, "reset_read");
    op(Id + 8'd1, 32'h0, 32'h0, 32'h0, 1'b0, "wrong_id");

    repeat (3) pulse(0, 100, 300);
    op(Id, 32'd0, 32'h0, 32'h8000_0064, 1'b1, "ch0_width");
    op(Id, 32'd1, 32'h0, 32'h8000_0190, 1'b1, "ch0_period");
    op(Id, 32'd4, 32'h0, 32'h0000_0005, 1'b1, "ch0_status");

    repeat (10) pulse(1, 1, 1);
    op(Id, 32'd2, 32'h0, 32'h8000_0001, 1'b1, "ch1_width");
    op(Id, 32'd3, 32'h0, 32'h8000_0002, 1'b1, "ch1_period");
    op(Id, 32'd0, 32'h0, 32'h8000_0064, 1'b1, "ch0_unaffected");

    // Stuck high on ch0 while ch1 idles low: both time out.
    pwm[0] = 1'b1;
    repeat (4200) step();
    op(Id, 32'd4, 32'h0, 32'h0000_0070, 1'b1, "tmo_status");
    op(Id, 32'd0, 32'h0, 32'h4000_0064, 1'b1, "tmo_width_held");
    pwm[0] = 1'b0;
    repeat (5) step();
    pulse(0, 37, 20);
    op(Id, 32'd0, 32'h0, 32'hC000_0025, 1'b1, "restart_width");
    repeat (2) pulse(0, 37, 20);
    op(Id, 32'd4, 32'h0, 32'h0000_0035, 1'b1, "pre_clear_status");

    op(Id, 32'h8, 32'h1, 32'hC000_0025, 1'b1, "clear_same_cycle");
    op(Id, 32'd4, 32'h0, 32'h0000_0020, 1'b1, "post_clear_status");

    // Clear issued in the cycle the falling edge is detected.
    pwm[0] = 1'b1;
    repeat (10) step();
    pwm[0] = 1'b0;
    repeat (2) step();
    op(Id, 32'h8, 32'h1, 32'h0000_0025, 1'b1, "clear_vs_fall");
    op(Id, 32'd4, 32'h0, 32'h0000_0021, 1'b1, "capture_wins");

    cnt[0] = 1; cnt[1] = 3;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (cnt[ch] == 0) begin
          pwm[ch] = ~pwm[ch];
          cnt[ch] = ($urandom_range(0, 60) == 0) ? int'($urandom_range(3000, 4500))
                                                  : int'($urandom_range(1, 25));
        end else begin
          cnt[ch]--;
        end
      end
      bus.start   = ($urandom_range(0, 2) == 0);
      bus.ci_n    = ($urandom_range(0, 5) == 0) ? 8'($urandom) : Id;
      va          = $urandom;
      va[3]       = ($urandom_range(0, 9) == 0);
      bus.value_a = va;
      bus.value_b = $urandom;
      step();
    end
    bus.start = 1'b0; bus.value_a = '0; bus.value_b = '0;

    pwm = 2'b00;
    step();
    pwm = 2'b11;
    repeat (20) step();
    reset = 1'b1;
    pwm = 2'b00;
    step();
    reset = 1'b0;
    for (int s = 0; s < 5; s++) op(Id, 32'(s), 32'h0, 32'h0, 1'b1, "post_reset_read");
    repeat (3) pulse(0, 50, 150);
    op(Id, 32'd0, 32'h0, 32'h8000_0032, 1'b1, "train_width");
    op(Id, 32'd1, 32'h0, 32'h8000_00C8, 1'b1, "train_period");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
